rom_line_cache: RTL and testbench



---
 rtl/rom_line_cache.sv | 239 +++++++++++++++++++++++
 tb/tb_rom_line_cache.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_line_cache.sv
`timescale 1ns/1ps
// rom_line_cache: direct-mapped, read-allocating, write-through line cache
// in front of one toggle-handshake port of the SDRAM controller.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cpu_req/addr/we/be/din CPU access request (word address [23:1])
//   cpu_dout/ack/busy     CPU read data, completion pulse, busy flag
//   inval                 pulse clearing all valid bits
//   mem_addr/wrl/wrh/din  controller request payload
//   mem_req/mem_ack       toggle request / acknowledge, mem_dout read data
module rom_line_cache #(
  parameter int unsigned INDEX_BITS = 4,
  parameter logic        MEM_BASE   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [22:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_busy,
  input  logic        inval,
  output logic [23:0] mem_addr,
  output logic        mem_wrl,
  output logic        mem_wrh,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        mem_req,
  input  logic        mem_ack
);
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 21 - INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL_ISSUE, S_FILL_WAIT, S_WR_WAIT, S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [15:0]           data_q [LINES][4];

  logic [15:0]           cpu_dout_q, cpu_dout_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  cpu_busy_q, cpu_busy_d;
  logic [23:0]           mem_addr_q, mem_addr_d;
  logic                  mem_wrl_q, mem_wrl_d;
  logic                  mem_wrh_q, mem_wrh_d;
  logic [15:0]           mem_din_q, mem_din_d;
  logic                  mem_req_q, mem_req_d;
  logic [INDEX_BITS-1:0] line_idx_q, line_idx_d;
  logic [TAG_BITS-1:0]   line_tag_q, line_tag_d;
  logic [1:0]            fill_cnt_q, fill_cnt_d;
  logic [1:0]            fill_num_q, fill_num_d;
  logic                  inval_pend_q, inval_pend_d;

  logic                  dat_we_c;
  logic [INDEX_BITS-1:0] dat_idx_c;
  logic [1:0]            dat_off_c;
  logic [1:0]            dat_be_c;
  logic [15:0]           dat_wdata_c;
  logic                  tag_we_c;

  logic [1:0]            req_off;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit_c;
  logic                  ack_match_c;

  assign req_off = cpu_addr[1:0];
  assign req_idx = cpu_addr[INDEX_BITS+1:2];
  assign req_tag = cpu_addr[22:INDEX_BITS+2];

  // inval in the same cycle wins over the lookup
  assign hit_c       = valid_q[req_idx] && !inval && (tag_q[req_idx] == req_tag);
  assign ack_match_c = (mem_ack == mem_req_q);

  assign cpu_dout = cpu_dout_q;
  assign cpu_ack  = cpu_ack_q;
  assign cpu_busy = cpu_busy_q;
  assign mem_addr = mem_addr_q;
  assign mem_wrl  = mem_wrl_q;
  assign mem_wrh  = mem_wrh_q;
  assign mem_din  = mem_din_q;
  assign mem_req  = mem_req_q;

  // State register; reset with an outstanding request waits it out in DRAIN
  always_ff @(posedge clk) begin
    if (reset) state_q <= ack_match_c ? S_IDLE : S_DRAIN;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (cpu_req) state_d = cpu_we ? S_WR_WAIT : (hit_c ? S_IDLE : S_FILL_ISSUE);
      S_FILL_ISSUE: state_d = S_FILL_WAIT;
      S_FILL_WAIT:  if (ack_match_c) state_d = (fill_num_q == 2'd3) ? S_IDLE : S_FILL_ISSUE;
      S_WR_WAIT:    if (ack_match_c) state_d = S_IDLE;
      S_DRAIN:      if (ack_match_c) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cpu_ack_d    = 1'b0;
    cpu_dout_d   = cpu_dout_q;
    cpu_busy_d   = (state_d != S_IDLE);
    mem_addr_d   = mem_addr_q;
    mem_wrl_d    = mem_wrl_q;
    mem_wrh_d    = mem_wrh_q;
    mem_din_d    = mem_din_q;
    mem_req_d    = mem_req_q;
    line_idx_d   = line_idx_q;
    line_tag_d   = line_tag_q;
    fill_cnt_d   = fill_cnt_q;
    fill_num_d   = fill_num_q;
    inval_pend_d = inval_pend_q;
    valid_d      = inval ? '0 : valid_q;
    dat_we_c     = 1'b0;
    dat_idx_c    = line_idx_q;
    dat_off_c    = fill_cnt_q;
    dat_be_c     = 2'b11;
    dat_wdata_c  = mem_dout;
    tag_we_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            mem_addr_d = {MEM_BASE, cpu_addr};
            mem_din_d  = cpu_din;
            mem_wrh_d  = cpu_be[1];
            mem_wrl_d  = cpu_be[0];
            mem_req_d  = ~mem_req_q;
            if (hit_c) begin
              dat_we_c    = 1'b1;
              dat_idx_c   = req_idx;
              dat_off_c   = req_off;
              dat_be_c    = cpu_be;
              dat_wdata_c = cpu_din;
            end
          end else if (hit_c) begin
            cpu_ack_d  = 1'b1;
            cpu_dout_d = data_q[req_idx][req_off];
          end else begin
            line_idx_d       = req_idx;
            line_tag_d       = req_tag;
            fill_cnt_d       = req_off;
            fill_num_d       = 2'd0;
            inval_pend_d     = 1'b0;
            valid_d[req_idx] = 1'b0;
            tag_we_c         = 1'b1;
          end
        end
      end
      S_FILL_ISSUE: begin
        mem_addr_d = {MEM_BASE, line_tag_q, line_idx_q, fill_cnt_q};
        mem_wrl_d  = 1'b0;
        mem_wrh_d  = 1'b0;
        mem_req_d  = ~mem_req_q;
        if (inval) inval_pend_d = 1'b1;
      end
      S_FILL_WAIT: begin
        if (inval) inval_pend_d = 1'b1;
        if (ack_match_c) begin
          dat_we_c = 1'b1;
          // first returned word is the one the CPU asked for
          if (fill_num_q == 2'd0) begin
            cpu_ack_d  = 1'b1;
            cpu_dout_d = mem_dout;
          end
          fill_cnt_d = fill_cnt_q + 2'd1;
          fill_num_d = fill_num_q + 2'd1;
          if (fill_num_q == 2'd3 && !inval_pend_q && !inval) valid_d[line_idx_q] = 1'b1;
        end
      end
      S_WR_WAIT: begin
        if (ack_match_c) begin
          cpu_ack_d = 1'b1;
          mem_wrl_d = 1'b0;
          mem_wrh_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_ack_q    <= 1'b0;
      cpu_dout_q   <= 16'h0000;
      cpu_busy_q   <= !ack_match_c;
      mem_addr_q   <= 24'h000000;
      mem_wrl_q    <= 1'b0;
      mem_wrh_q    <= 1'b0;
      mem_din_q    <= 16'h0000;
      line_idx_q   <= '0;
      line_tag_q   <= '0;
      fill_cnt_q   <= 2'd0;
      fill_num_q   <= 2'd0;
      inval_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      cpu_ack_q    <= cpu_ack_d;
      cpu_dout_q   <= cpu_dout_d;
      cpu_busy_q   <= cpu_busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_wrl_q    <= mem_wrl_d;
      mem_wrh_q    <= mem_wrh_d;
      mem_din_q    <= mem_din_d;
      line_idx_q   <= line_idx_d;
      line_tag_q   <= line_tag_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_num_q   <= fill_num_d;
      inval_pend_q <= inval_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Request toggle and line storage; mem_req is held through reset to stay paired with mem_ack
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req_q <= mem_req_d;
      if (dat_we_c) begin
        if (dat_be_c[0]) data_q[dat_idx_c][dat_off_c][7:0]  <= dat_wdata_c[7:0];
        if (dat_be_c[1]) data_q[dat_idx_c][dat_off_c][15:8] <= dat_wdata_c[15:8];
      end
      if (tag_we_c) tag_q[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_rom_line_cache.sv
`timescale 1ns/1ps
// Bench for rom_line_cache: toggle-handshake SDRAM controller model with
// its own memory, plus a reference memory/cache-occupancy model.
module tb_rom_line_cache;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_be = 2'b00;
  logic [15:0] cpu_din = '0;
  logic [15:0] cpu_dout;
  logic        cpu_ack, cpu_busy;
  logic        inval = 1'b0;
  logic [23:0] mem_addr;
  logic        mem_wrl, mem_wrh;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;
  logic        mem_req;
  logic        mem_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  rom_line_cache #(.INDEX_BITS(4), .MEM_BASE(1'b0)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_ack(cpu_ack), .cpu_busy(cpu_busy), .inval(inval), .mem_addr(mem_addr),
    .mem_wrl(mem_wrl), .mem_wrh(mem_wrh), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_req(mem_req), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic        wrh;
    logic        wrl;
    logic [15:0] din;
  } req_t;

  req_t        log_q[$];
  logic [15:0] ctl_mem [int];
  logic [15:0] ref_mem [int];
  bit          rv [16];
  int          rt [16];

  // Controller model: captures a request when mem_req differs from mem_ack,
  // answers lat_cfg cycles later
  int   lat_cfg = 6;
  bit   ctl_busy = 1'b0;
  int   ctl_cnt = 0;
  req_t ctl_cur;

  function automatic logic [15:0] ctl_rd(input int a);
    if (ctl_mem.exists(a)) return ctl_mem[a];
    return 16'(a) ^ 16'hA5A5;
  endfunction

  always @(posedge clk) begin
    if (ctl_busy) begin
      ctl_cnt = ctl_cnt - 1;
      if (ctl_cnt == 0) begin
        if (ctl_cur.wrh || ctl_cur.wrl) begin
          logic [15:0] v;
          v = ctl_rd(int'(ctl_cur.addr));
          if (ctl_cur.wrh) v[15:8] = ctl_cur.din[15:8];
          if (ctl_cur.wrl) v[7:0]  = ctl_cur.din[7:0];
          ctl_mem[int'(ctl_cur.addr)] = v;
        end
        mem_dout <= ctl_rd(int'(ctl_cur.addr));
        mem_ack  <= ~mem_ack;
        ctl_busy = 1'b0;
      end
    end else if (mem_req !== mem_ack) begin
      ctl_cur.addr = mem_addr;
      ctl_cur.wrh  = mem_wrh;
      ctl_cur.wrl  = mem_wrl;
      ctl_cur.din  = mem_din;
      log_q.push_back(ctl_cur);
      ctl_busy = 1'b1;
      ctl_cnt  = lat_cfg;
    end
  end

  // Reference model: flat memory plus which line tag each index holds
  function automatic logic [15:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 16'(a) ^ 16'hA5A5;
  endfunction

  function automatic void ref_wr(input int a, input logic [1:0] be, input logic [15:0] d);
    logic [15:0] v;
    v = ref_rd(a);
    if (be[1]) v[15:8] = d[15:8];
    if (be[0]) v[7:0]  = d[7:0];
    ref_mem[a] = v;
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < 16; i++) rv[i] = 1'b0;
  endfunction

  function automatic bit ref_hit(input int a);
    return rv[(a >> 2) & 15] && (rt[(a >> 2) & 15] == (a >> 6));
  endfunction

  function automatic void ref_fill(input int a);
    rv[(a >> 2) & 15] = 1'b1;
    rt[(a >> 2) & 15] = a >> 6;
  endfunction

  // One CPU access; returns data, cycles to cpu_ack, toggles, extra acks
  task automatic do_access(input logic we, input logic [22:0] a, input logic [1:0] be,
                           input logic [15:0] din, input logic inv,
                           output logic [15:0] rdata, output int lat, output int toggles,
                           output int extra, output bit tmo);
    int l0;
    l0 = log_q.size();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_din = din; inval = inv;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0; inval = 1'b0;
    lat = 1; tmo = 1'b1; rdata = '0; extra = 0;
    for (int i = 0; i < 300; i++) begin
      if (cpu_ack) begin rdata = cpu_dout; tmo = 1'b0; break; end
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 300 && cpu_busy; i++) begin
      @(posedge clk); #1;
      if (cpu_ack) extra++;
    end
    toggles = log_q.size() - l0;
  endtask

  task automatic pulse_inval();
    @(negedge clk); inval = 1'b1;
    @(negedge clk); inval = 1'b0;
  endtask

  logic [15:0] rd;
  int lat, tg, ex, l0;
  bit tmo, ok;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    ref_clear();
    total++;
    if ({cpu_ack, cpu_busy, mem_wrl, mem_wrh} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {cpu_ack, cpu_busy, mem_wrl, mem_wrh});
    end
    total++;
    if ({cpu_dout, mem_din, mem_addr} !== 56'h0) begin
      bad++; $display("FAIL reset_data got dout=%h din=%h addr=%h exp=0", cpu_dout, mem_din, mem_addr);
    end
    total++;
    if (mem_req !== mem_ack) begin bad++; $display("FAIL reset_pair req=%b ack=%b", mem_req, mem_ack); end
  endtask

  task automatic test_first_fill();
    l0 = log_q.size();
    do_access(1'b0, 23'h000010, 2'b00, 16'h0, 1'b0, rd, lat, tg, ex, tmo);
    total++;
    if (tmo || rd !== 16'hA5B5) begin bad++; $display("FAIL fill0_data got=%h exp=a5b5 tmo=%0d", rd, tmo); end
    total++;
    if (tg != 4 || ex != 0 || lat <= 1) begin
      bad++; $display("FAIL fill0_toggles got tg=%0d extra=%0d lat=%0d exp tg=4 extra=0", tg, ex, lat);
    end
    ok = (tg == 4);
    for (int k = 0; k < 4 && ok; k++)
      if (log_q[l0+k].addr !== 24'h10 + 24'(k) || log_q[l0+k].wrh || log_q[l0+k].wrl) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL fill0_order got first=%h exp=000010..000013 reads", log_q[l0].addr); end
    ref_fill(32'h10);
    do_access(1'b0, 23'h000013, 2'b00, 16'h0, 1'b0, rd, lat, tg, ex, tmo);
    total++;
    if (tmo || rd !== 16'hA5B6 || lat != 1 || tg != 0) begin
      bad++; $display("FAIL rehit got=%h lat=%0d tg=%0d exp=a5b6 lat=1 tg=0", rd, lat, tg);
    end
  endtask

  task automatic test_critical_word();
    pulse_inval();
    ref_clear();
    l0 = log_q.size();
    do_access(1'b0, 23'h000012, 2'b00, 16'h0, 1'b0, rd, lat, tg, ex, tmo);
    total++;
    if (tmo || rd !== 16'hA5B7 || tg != 4 || ex != 0) begin
      bad++; $display("FAIL crit_data got=%h tg=%0d extra=%0d exp=a5b7 tg=4 extra=0", rd, tg, ex);
    end
    ok = (tg == 4);
    for (int k = 0; k < 4 && ok; k++)
      if (log_q[l0+k].addr !== 24'h10 + 24'((k + 2) % 4)) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL crit_order got first=%h exp order 12,13,10,11", log_q[l0].addr); end
    ref_fill(32'h12);
    do_access(1'b0, 23'h000010, 2'b00, 16'h0, 1'b0, rd, lat, tg, ex, tmo);
    total++;
    if (rd !== 16'hA5B5 || lat != 1 || tg != 0) begin
      bad++; $display("FAIL crit_valid got=%h lat=%0d tg=%0d exp=a5b5 lat=1 tg=0", rd, lat, tg);
    end
  endtask

  task automatic test_write_hit();
    ctl_mem[32'h45] = 16'h1234;
    ref_mem[32'h45] = 16'h1234;
    do_access(1'b0, 23'h000045, 2'b00, 16'h0, 1'b0, rd, lat, tg, ex, tmo);
    total++;
    if (tmo || rd !== 16'h1234 || tg != 4) begin bad++; $display("FAIL wh_fill got=%h tg=%0d exp=1234 tg=4", rd, tg); end
    ref_fill(32'h45);
    l0 = log_q.size();
    do_access(1'b1, 23'h000045, 2'b10, 16'hBEEF, 1'b0, rd, lat, tg, ex, tmo);
    ref_wr(32'h45, 2'b10, 16'hBEEF);
    total++;
    if (tmo || tg != 1) begin bad++; $display("FAIL wh_toggles got=%0d exp=1 tmo=%0d", tg, tmo); end
    else begin
      total++;
      if (log_q[l0].addr !== 24'h45 || log_q[l0].wrh !== 1'b1 || log_q[l0].wrl !== 1'b0 || log_q[l0].din !== 16'hBEEF) begin
        bad++; $display("FAIL wh_strobes got addr=%h wrh=%b wrl=%b din=%h exp 000045 1 0 beef",
                        log_q[l0].addr, log_q[l0].wrh, log_q[l0].wrl, log_q[l0].din);
      end
    end
    do_access(1'b0, 23'h000045, 2'b00, 16'h0, 1'b0, rd, lat, tg, ex, tmo);
    total++;
    if (rd !== 16'hBE34 || lat != 1 || tg != 0) begin
      bad++; $display("FAIL wh_merge got=%h lat=%0d tg=%0d exp=be34 lat=1 tg=0", rd, lat, tg);
    end
  endtask

  task automatic test_write_miss();
    logic [15:0] d;
    d = 16'($urandom);
    do_access(1'b1, 23'h001003, 2'b11, d, 1'b0, rd, lat, tg, ex, tmo);
    ref_wr(32'h1003, 2'b11, d);
    total++;
    if (tmo || tg != 1 || ex != 0) begin bad++; $display("FAIL wm_toggles got=%0d exp=1", tg); end
    do_access(1'b0, 23'h001003, 2'b00, 16'h0, 1'b0, rd, lat, tg, ex, tmo);
    total++;
    if (tmo || rd !== d || tg != 4 || lat <= 1) begin
      bad++; $display("FAIL wm_readback got=%h tg=%0d lat=%0d exp=%h tg=4", rd, tg, lat, d);
    end
    ref_fill(32'h1003);
  endtask

  task automatic test_inval_mid_fill();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000200;
    @(posedge clk); #1; cpu_req = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (cpu_ack) begin tmo = 1'b0; break; end
      @(posedge clk); #1;
    end
    pulse_inval();
    for (int i = 0; i < 200 && cpu_busy; i++) @(negedge clk);
    total++;
    if (tmo || cpu_busy) begin bad++; $display("FAIL imf_first got tmo=%0d busy=%b exp 0 0", tmo, cpu_busy); end
    ref_clear();
    do_access(1'b0, 23'h000200, 2'b00, 16'h0, 1'b0, rd, lat, tg, ex, tmo);
    total++;
    if (tmo || tg != 4 || rd !== ref_rd(32'h200)) begin
      bad++; $display("FAIL imf_refetch got tg=%0d data=%h exp tg=4 data=%h", tg, rd, ref_rd(32'h200));
    end
    ref_fill(32'h200);
  endtask

  task automatic test_drain();
    int acks, l1;
    lat_cfg = 5;
    l0 = log_q.size();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000300;
    @(posedge clk); #1; cpu_req = 1'b0;
    for (int i = 0; i < 20 && mem_req === mem_ack; i++) begin @(posedge clk); #1; end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    ref_clear();
    total++;
    if (cpu_busy !== 1'b1) begin bad++; $display("FAIL drain_busy got=%b exp=1", cpu_busy); end
    l1 = log_q.size();
    acks = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cpu_ack) acks++;
      if (!cpu_busy) begin tmo = 1'b0; break; end
      @(negedge clk);
    end
    repeat (4) begin @(negedge clk); if (cpu_ack) acks++; end
    total++;
    if (tmo || acks != 0 || log_q.size() != l1 || l1 - l0 != 1 || mem_req !== mem_ack) begin
      bad++; $display("FAIL drain_quiet got tmo=%0d acks=%0d toggles=%0d pre=%0d paired=%b exp 0 0 0 1 1",
                      tmo, acks, log_q.size() - l1, l1 - l0, mem_req === mem_ack);
    end
    lat_cfg = 6;
    do_access(1'b0, 23'h000300, 2'b00, 16'h0, 1'b0, rd, lat, tg, ex, tmo);
    total++;
    if (tmo || tg != 4 || rd !== ref_rd(32'h300) || mem_req !== mem_ack) begin
      bad++; $display("FAIL drain_refill got tg=%0d data=%h exp tg=4 data=%h", tg, rd, ref_rd(32'h300));
    end
    ref_fill(32'h300);
  endtask

  task automatic test_random();
    int tags[3];
    int a, op, base;
    bit inv, hit;
    logic [1:0] be;
    logic [15:0] d, exp_d;
    tags[0] = 0; tags[1] = 1; tags[2] = 32'h1FFFF;
    for (int n = 0; n < 80; n++) begin
      a = (tags[$urandom_range(0, 2)] << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      inv = ($urandom_range(0, 7) == 0);
      lat_cfg = $urandom_range(1, 8);
      if (op == 9) begin
        pulse_inval();
        ref_clear();
      end else if (op < 6) begin
        if (inv) ref_clear();
        hit = ref_hit(a);
        exp_d = ref_rd(a);
        l0 = log_q.size();
        do_access(1'b0, 23'(a), 2'b00, 16'h0, inv, rd, lat, tg, ex, tmo);
        total++;
        if (tmo || rd !== exp_d || ex != 0) begin
          bad++; $display("FAIL rnd_read a=%h got=%h exp=%h tmo=%0d extra=%0d", a, rd, exp_d, tmo, ex);
        end
        if (hit) begin
          total++;
          if (lat != 1 || tg != 0) begin bad++; $display("FAIL rnd_hit a=%h lat=%0d tg=%0d exp 1 0", a, lat, tg); end
        end else begin
          base = a & ~3;
          ok = (tg == 4);
          for (int k = 0; k < 4 && ok; k++)
            if (log_q[l0+k].addr !== 24'(base | ((a + k) & 3)) || log_q[l0+k].wrh || log_q[l0+k].wrl) ok = 1'b0;
          total++;
          if (!ok) begin bad++; $display("FAIL rnd_fill a=%h tg=%0d exp 4 ordered reads", a, tg); end
          ref_fill(a);
        end
      end else begin
        if (inv) ref_clear();
        be = 2'($urandom_range(1, 3));
        d = 16'($urandom);
        l0 = log_q.size();
        do_access(1'b1, 23'(a), be, d, inv, rd, lat, tg, ex, tmo);
        ref_wr(a, be, d);
        total++;
        if (tmo || tg != 1 || ex != 0) begin
          bad++; $display("FAIL rnd_wr_tg a=%h tg=%0d tmo=%0d exp 1 0", a, tg, tmo);
        end else begin
          total++;
          if (log_q[l0].addr !== 24'(a) || {log_q[l0].wrh, log_q[l0].wrl} !== be || log_q[l0].din !== d) begin
            bad++; $display("FAIL rnd_wr_req got addr=%h be=%b din=%h exp %h %b %h",
                            log_q[l0].addr, {log_q[l0].wrh, log_q[l0].wrl}, log_q[l0].din, 24'(a), be, d);
          end
        end
      end
    end
    lat_cfg = 6;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fill();
    test_critical_word();
    test_write_hit();
    test_write_miss();
    test_inval_mid_fill();
    test_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
